bayes_infer_master: RTL and testbench
=====================================

// Module: bayes_infer_master
// PURPOSE
//  AXI-Lite initiator that runs one Bayesian inference on the chip_control slave per command.
//  Command: mode bit plus four 9-bit observations.
//  Sequence: writes stoch_log reg, writes O1..O4 regs, reads result word at BASE_ADDR+0x2000,
//  then returns the result (4 x 8-bit class scores) or an error.
//  Sits between a host/CPU-side command source and the chip_control AXI_LITE slave port.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte base of the chip_control window
//  TIMEOUT_CYC  4096           max cycles waited in any single AXI phase before abort (>=16)
//  WRITE_MODE   1              1: write reg7 (stoch_log) each command; 0: skip that write
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous active-low reset
//  cmd_valid      in   1   command valid
//  cmd_ready      out  1   command accepted when valid&ready
//  cmd_mode       in   1   0 stoch / 1 log, written to reg7
//  cmd_obs        in   36  {O4,O3,O2,O1}, 9 bits each ({row[5:0],col[2:0]})
//  res_valid      out  1   result valid, held until res_ready
//  res_ready      in   1   result consumer ready
//  res_data       out  32  result word (byte k = class k score); 0 on error
//  res_err        out  1   1 = transaction failed
//  res_code       out  2   0 ok, 1 SLVERR/DECERR on B, 2 SLVERR/DECERR on R, 3 timeout
//  busy           out  1   high from command accept until result handshake
//  axi            master   AXI_LITE master modport (aw/w/b/ar/r), 32-bit addr/data
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE; cmd_ready=1; res_valid=0; res_data=0; res_err=0;
//   res_code=0; busy=0; aw/w/ar_valid=0; b_ready=r_ready=0; step=0; timer=0.
//  Reset mid-transaction drops all valids immediately; no recovery of in-flight data.
//  FSM: IDLE -> WR -> WB -> (next write | RA) -> RR -> DONE -> IDLE; any phase -> DONE on error.
//  IDLE: cmd_ready=1; on cmd_valid latch mode/obs, busy=1.
//   step = WRITE_MODE ? 0 : 1; go WR.
//  Write targets by step:
//   0 = reg7 @BASE+0x201C, data {31'b0,mode}
//   1..4 = O1..O4 @BASE+0x200C/0x2010/0x2014/0x2018, data {23'b0,Ok}
//  WR: aw_valid and w_valid asserted in the same cycle, wstrb=4'hF, prot=0.
//   Each valid drops the cycle after its own ready is seen; aw/w payload stable while valid.
//   Slave requires both valids together, so neither is withdrawn early.
//   When both accepted -> WB.
//  WB: b_ready=1 held until b_valid.
//   bresp!=0 -> DONE with err, code 1.
//   Otherwise step==4 -> RA, else step++ and -> WR.
//  RA: ar_valid=1, araddr=BASE+0x2000, held until ar_ready -> RR.
//  RR: r_ready=1 continuously until r_valid; the slave only issues data while r_ready is high.
//   rresp!=0 -> err code 2; else res_data=rdata. -> DONE.
//  DONE: res_valid=1; on res_valid&res_ready -> IDLE, busy=0, cmd_ready=1 next cycle.
//  Timer: cleared on every phase entry, increments each cycle in WR/WB/RA/RR.
//   timer==TIMEOUT_CYC-1 without completion -> drop all valids/readys, err code 3, DONE.
//   Counter saturates; never wraps.
//  Only one AXI transaction outstanding; reads and writes never overlap.
//  Handshakes landing in the same cycle as timer expiry count as success (handshake wins).
//  cmd_valid while busy: ignored (cmd_ready=0), command stays pending at source.
//  Min latency with a zero-wait slave: 5 writes x 2 + 2 read + 1 = 13 cycles from accept to res_valid.
//  Each write costs >=2 cycles (WR, WB). The slave adds ~4 inference passes before R.
// TESTING
//  1 Reset: rst_n=0 mid-WR -> aw_valid/w_valid=0 same cycle; after release cmd_ready=1, res_valid=0.
//  2 Nominal, zero-wait responder: mode=1, obs={9'h1FF,9'h0A5,9'h012,9'h003}.
//    Expect 5 writes in order 0x201C=1, 0x200C=3, 0x2010=0x12, 0x2014=0xA5, 0x2018=0x1FF.
//    Then read 0x2000 returns 0x11223344 -> res_data=0x11223344, res_err=0, res_code=0.
//  3 Skewed write ready: aw_ready 3 cycles before w_ready -> aw_valid drops after its ready.
//    w_valid holds; exactly one B waited per write.
//  4 bresp=2'b10 on the O2 write -> res_err=1, res_code=1, res_data=0, no ar_valid ever issued.
//  5 Timeout: TIMEOUT_CYC=16, slave never raises r_valid -> res_valid 16 cycles after RR entry.
//    res_code=3, r_ready low afterwards.
//  6 Backpressure: res_ready=0 for 10 cycles -> res_valid/res_data stable, cmd_valid ignored.
//    res_ready=1 -> next command accepted 1 cycle later.

Source files
------------

// File: rtl/bayes_infer_master_if.sv
// AXI-Lite bus bundle between the inference initiator and the chip_control slave.
// 32-bit address/data, single outstanding transaction per direction.
interface axi_lite_if;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] aw_addr;
    logic [2:0]  aw_prot;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_resp;
    logic        ar_valid;
    logic        ar_ready;
    logic [31:0] ar_addr;
    logic [2:0]  ar_prot;
    logic        r_valid;
    logic        r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        output ar_valid, ar_addr, ar_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );

    modport slave (
        input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready,
        input  ar_valid, ar_addr, ar_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
    );
endinterface

// File: rtl/bayes_infer_master.sv
// AXI-Lite initiator that runs one Bayesian inference on chip_control per command:
// optional stoch_log write, four observation writes, one result read, then a
// result/error report held until the consumer takes it.
module bayes_infer_master #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter bit          WRITE_MODE  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_mode,
    input  logic [35:0] cmd_obs,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic [1:0]  res_code,
    output logic        busy,
    axi_lite_if.master  axi
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [2:0]    FIRST_STEP = WRITE_MODE ? 3'd0 : 3'd1;
    localparam logic [2:0]    LAST_STEP  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_WB, S_RA, S_RR, S_DONE} state_e;
    typedef enum logic [1:0] {CODE_OK, CODE_BRESP, CODE_RRESP, CODE_TIMEOUT} code_e;

    state_e         state;
    logic [2:0]     step;
    logic [TW-1:0]  timer;
    logic           mode_q;
    logic [35:0]    obs_q;
    logic           aw_valid_q;
    logic           w_valid_q;
    logic           aw_done;
    logic           w_done;
    logic           b_ready_q;
    logic           ar_valid_q;
    logic           r_ready_q;
    logic [31:0]    aw_addr_q;
    logic [31:0]    w_data_q;

    // Register address for each write step: reg7 first, then O1..O4.
    function automatic logic [31:0] wr_addr(input logic [2:0] s);
        logic [15:0] off;
        case (s)
            3'd0:    off = 16'h201C;
            3'd1:    off = 16'h200C;
            3'd2:    off = 16'h2010;
            3'd3:    off = 16'h2014;
            default: off = 16'h2018;
        endcase
        return BASE_ADDR + {16'h0000, off};
    endfunction

    // Write payload for each step: mode bit for reg7, zero-extended 9-bit observation otherwise.
    function automatic logic [31:0] wr_data(input logic [2:0] s, input logic m, input logic [35:0] o);
        case (s)
            3'd0:    return {31'b0, m};
            3'd1:    return {23'b0, o[8:0]};
            3'd2:    return {23'b0, o[17:9]};
            3'd3:    return {23'b0, o[26:18]};
            default: return {23'b0, o[35:27]};
        endcase
    endfunction

    logic aw_hs;
    logic w_hs;
    logic aw_ok;
    logic w_ok;
    logic expired;

    assign aw_hs   = aw_valid_q && axi.aw_ready;
    assign w_hs    = w_valid_q && axi.w_ready;
    assign aw_ok   = aw_done || aw_hs;
    assign w_ok    = w_done || w_hs;
    assign expired = (timer == TIMER_LAST);

    assign axi.aw_valid = aw_valid_q;
    assign axi.aw_addr  = aw_addr_q;
    assign axi.aw_prot  = 3'b000;
    assign axi.w_valid  = w_valid_q;
    assign axi.w_data   = w_data_q;
    assign axi.w_strb   = 4'hF;
    assign axi.b_ready  = b_ready_q;
    assign axi.ar_valid = ar_valid_q;
    assign axi.ar_addr  = BASE_ADDR + 32'h0000_2000;
    assign axi.ar_prot  = 3'b000;
    assign axi.r_ready  = r_ready_q;

    // Command sequencer: one AXI phase at a time, every output registered.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so the bus and result ports are defined from reset.
        if (!rst_n) begin
            state      <= S_IDLE;
            step       <= 3'd0;
            timer      <= '0;
            mode_q     <= 1'b0;
            obs_q      <= '0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
            res_code   <= CODE_OK;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        mode_q     <= cmd_mode;
                        obs_q      <= cmd_obs;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        res_err    <= 1'b0;
                        res_code   <= CODE_OK;
                        step       <= FIRST_STEP;
                        aw_addr_q  <= wr_addr(FIRST_STEP);
                        w_data_q   <= wr_data(FIRST_STEP, cmd_mode, cmd_obs);
                        aw_valid_q <= 1'b1;
                        w_valid_q  <= 1'b1;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        timer      <= '0;
                        state      <= S_WR;
                    end
                end

                S_WR: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid_q <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        b_ready_q <= 1'b1;
                        timer     <= '0;
                        state     <= S_WB;
                    end else if (expired) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b0;
                        res_valid  <= 1'b1;
                        res_data   <= '0;
                        res_err    <= 1'b1;
                        res_code   <= CODE_TIMEOUT;
                        state      <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_WB: begin
                    if (axi.b_valid) begin
                        b_ready_q <= 1'b0;
                        timer     <= '0;
                        if (axi.b_resp != 2'b00) begin
                            res_valid <= 1'b1;
                            res_data  <= '0;
                            res_err   <= 1'b1;
                            res_code  <= CODE_BRESP;
                            state     <= S_DONE;
                        end else if (step == LAST_STEP) begin
                            ar_valid_q <= 1'b1;
                            state      <= S_RA;
                        end else begin
                            step       <= step + 3'd1;
                            aw_addr_q  <= wr_addr(step + 3'd1);
                            w_data_q   <= wr_data(step + 3'd1, mode_q, obs_q);
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done    <= 1'b0;
                            w_done     <= 1'b0;
                            state      <= S_WR;
                        end
                    end else if (expired) begin
                        b_ready_q <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_code  <= CODE_TIMEOUT;
                        state     <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RA: begin
                    if (axi.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        timer      <= '0;
                        state      <= S_RR;
                    end else if (expired) begin
                        ar_valid_q <= 1'b0;
                        res_valid  <= 1'b1;
                        res_data   <= '0;
                        res_err    <= 1'b1;
                        res_code   <= CODE_TIMEOUT;
                        state      <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_RR: begin
                    if (axi.r_valid) begin
                        r_ready_q <= 1'b0;
                        res_valid <= 1'b1;
                        if (axi.r_resp != 2'b00) begin
                            res_data <= '0;
                            res_err  <= 1'b1;
                            res_code <= CODE_RRESP;
                        end else begin
                            res_data <= axi.r_data;
                        end
                        state <= S_DONE;
                    end else if (expired) begin
                        r_ready_q <= 1'b0;
                        res_valid <= 1'b1;
                        res_data  <= '0;
                        res_err   <= 1'b1;
                        res_code  <= CODE_TIMEOUT;
                        state     <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bayes_infer_master.sv
// Self-checking bench for bayes_infer_master: table-driven commands against a
// configurable AXI-Lite responder, plus hand-written reset, skew, timeout and
// backpressure sequences.
module tb_bayes_infer_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_mode;
    logic [35:0] cmd_obs;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_err;
    logic [1:0]  res_code;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_if axi_bus ();

    bayes_infer_master #(
        .BASE_ADDR   (32'h0000_0000),
        .TIMEOUT_CYC (TO),
        .WRITE_MODE  (1'b1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_obs   (cmd_obs),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .res_code  (res_code),
        .busy      (busy),
        .axi       (axi_bus)
    );

    // ---------------- responder configuration ----------------
    int          aw_delay = 0;
    int          w_delay  = 0;
    int          fail_idx = -1;
    logic [1:0]  bresp_val = 2'b00;
    logic [1:0]  rresp_val = 2'b00;
    bit          r_never = 1'b0;
    logic [31:0] rdata_val = 32'h0;
    int          wr_start = 0;

    // ---------------- responder state ----------------
    int          aw_wait;
    int          w_wait;
    bit          aw_got;
    bit          w_got;
    logic [31:0] got_addr;
    logic [31:0] got_data;
    logic        s_b_valid;
    logic [1:0]  s_b_resp;
    logic        s_r_valid;
    logic [31:0] s_r_data;
    logic [1:0]  s_r_resp;
    int          wr_count;
    int          b_count;
    int          ar_count;
    int          ar_valid_cycles;
    logic [31:0] log_addr [256];
    logic [31:0] log_data [256];

    logic aw_hs_s;
    logic w_hs_s;

    assign axi_bus.aw_ready = axi_bus.aw_valid && !aw_got && (aw_wait >= aw_delay);
    assign axi_bus.w_ready  = axi_bus.w_valid && !w_got && (w_wait >= w_delay);
    assign axi_bus.b_valid  = s_b_valid;
    assign axi_bus.b_resp   = s_b_resp;
    assign axi_bus.ar_ready = axi_bus.ar_valid && !s_r_valid;
    assign axi_bus.r_valid  = s_r_valid;
    assign axi_bus.r_data   = s_r_data;
    assign axi_bus.r_resp   = s_r_resp;

    assign aw_hs_s = axi_bus.aw_valid && axi_bus.aw_ready;
    assign w_hs_s  = axi_bus.w_valid && axi_bus.w_ready;

    // Responder: accepts AW/W with programmable delays, answers B once both are in, R after AR.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_wait <= 0; w_wait <= 0; aw_got <= 1'b0; w_got <= 1'b0;
            got_addr <= '0; got_data <= '0;
            s_b_valid <= 1'b0; s_b_resp <= 2'b00;
            s_r_valid <= 1'b0; s_r_data <= '0; s_r_resp <= 2'b00;
        end else begin
            aw_wait <= aw_hs_s ? 0 : (axi_bus.aw_valid ? aw_wait + 1 : 0);
            w_wait  <= w_hs_s ? 0 : (axi_bus.w_valid ? w_wait + 1 : 0);
            if (aw_hs_s) begin aw_got <= 1'b1; got_addr <= axi_bus.aw_addr; end
            if (w_hs_s)  begin w_got <= 1'b1; got_data <= axi_bus.w_data; end
            if ((aw_got || aw_hs_s) && (w_got || w_hs_s) && !s_b_valid) begin
                log_addr[wr_count[7:0]] <= aw_hs_s ? axi_bus.aw_addr : got_addr;
                log_data[wr_count[7:0]] <= w_hs_s ? axi_bus.w_data : got_data;
                s_b_valid <= 1'b1;
                s_b_resp  <= ((wr_count - wr_start) == fail_idx) ? bresp_val : 2'b00;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
                wr_count  <= wr_count + 1;
            end
            if (s_b_valid && axi_bus.b_ready) begin
                s_b_valid <= 1'b0;
                b_count   <= b_count + 1;
            end
            if (axi_bus.ar_valid) ar_valid_cycles <= ar_valid_cycles + 1;
            if (axi_bus.ar_valid && axi_bus.ar_ready) begin
                ar_count <= ar_count + 1;
                if (!r_never) begin
                    s_r_valid <= 1'b1;
                    s_r_data  <= rdata_val;
                    s_r_resp  <= rresp_val;
                end
            end
            if (s_r_valid && axi_bus.r_ready) s_r_valid <= 1'b0;
        end
    end

    initial begin
        wr_count = 0; b_count = 0; ar_count = 0; ar_valid_cycles = 0;
    end

    // ---------------- protocol monitor ----------------
    int          viol = 0;
    int          skew_cycles = 0;
    logic        prev_aw_pend, prev_w_pend, prev_aw_hs, prev_w_hs;
    logic [31:0] prev_aw_addr, prev_w_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_aw_pend <= 1'b0; prev_w_pend <= 1'b0;
            prev_aw_hs <= 1'b0; prev_w_hs <= 1'b0;
            prev_aw_addr <= '0; prev_w_data <= '0;
        end else begin
            if (prev_aw_pend && (!axi_bus.aw_valid || axi_bus.aw_addr != prev_aw_addr)) viol <= viol + 1;
            if (prev_w_pend && (!axi_bus.w_valid || axi_bus.w_data != prev_w_data)) viol <= viol + 1;
            if ((prev_aw_hs && axi_bus.aw_valid) || (prev_w_hs && axi_bus.w_valid)) viol <= viol + 1;
            if ((axi_bus.aw_valid && axi_bus.aw_prot != 3'b0) || (axi_bus.w_valid && axi_bus.w_strb != 4'hF)) viol <= viol + 1;
            if (!axi_bus.aw_valid && axi_bus.w_valid) skew_cycles <= skew_cycles + 1;
            prev_aw_pend <= axi_bus.aw_valid && !axi_bus.aw_ready;
            prev_w_pend  <= axi_bus.w_valid && !axi_bus.w_ready;
            prev_aw_hs   <= aw_hs_s;
            prev_w_hs    <= w_hs_s;
            prev_aw_addr <= axi_bus.aw_addr;
            prev_w_data  <= axi_bus.w_data;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic issue_cmd(input logic m, input logic [35:0] o);
        int n = 0;
        @(negedge clk);
        cmd_mode  = m;
        cmd_obs   = o;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) check("cmd_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output logic [31:0] d, output logic e, output logic [1:0] c, output int rr);
        int n = 0;
        rr = 0;
        while (!res_valid && n < 400) begin
            if (axi_bus.r_ready) rr++;
            @(negedge clk);
            n++;
        end
        if (!res_valid) check("res_wait", 32'(res_valid), 32'd1);
        d = res_data;
        e = res_err;
        c = res_code;
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic [31:0] exp_addr(input int k);
        logic [31:0] tab [5];
        tab = '{32'h201C, 32'h200C, 32'h2010, 32'h2014, 32'h2018};
        return tab[k];
    endfunction

    function automatic logic [31:0] exp_wdata(input int k, input logic m, input logic [35:0] o);
        logic [35:0] sh;
        if (k == 0) return {31'b0, m};
        sh = o >> (9 * (k - 1));
        return {23'b0, sh[8:0]};
    endfunction

    typedef struct {
        logic        mode;
        logic [35:0] obs;
        int          fail;
        logic [1:0]  bresp;
        logic [1:0]  rresp;
        logic [31:0] rdata;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [1:0]  exp_code;
        int          exp_writes;
        int          exp_reads;
    } vec_t;

    vec_t vecs [6];

    // Safety net so the run always ends.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d, d0;
        logic        e;
        logic [1:0]  c;
        int          rr, w0, b0, a0, av0, s0, v0, bp_bad;

        vecs[0] = '{1'b1, {9'h1FF, 9'h0A5, 9'h012, 9'h003}, -1, 2'b00, 2'b00, 32'h1122_3344, 32'h1122_3344, 1'b0, 2'd0, 5, 1};
        vecs[1] = '{1'b0, {9'h000, 9'h155, 9'h0AA, 9'h1C7}, -1, 2'b00, 2'b00, 32'h80FF_007F, 32'h80FF_007F, 1'b0, 2'd0, 5, 1};
        vecs[2] = '{1'b1, {9'h100, 9'h0F0, 9'h00F, 9'h001}, 2, 2'b10, 2'b00, 32'hAAAA_5555, 32'h0, 1'b1, 2'd1, 3, 0};
        vecs[3] = '{1'b0, {9'h0C3, 9'h13C, 9'h081, 9'h17E}, 0, 2'b11, 2'b00, 32'hAAAA_5555, 32'h0, 1'b1, 2'd1, 1, 0};
        vecs[4] = '{1'b1, {9'h011, 9'h022, 9'h044, 9'h088}, 4, 2'b10, 2'b00, 32'hAAAA_5555, 32'h0, 1'b1, 2'd1, 5, 0};
        vecs[5] = '{1'b0, {9'h1AB, 9'h0CD, 9'h0EF, 9'h123}, -1, 2'b00, 2'b10, 32'hDEAD_BEEF, 32'h0, 1'b1, 2'd2, 5, 1};

        cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_obs = '0; res_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_err_code", {29'b0, res_err, res_code}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_bus_valids", {27'b0, axi_bus.aw_valid, axi_bus.w_valid, axi_bus.b_ready,
                                 axi_bus.ar_valid, axi_bus.r_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven commands
        for (int i = 0; i < 6; i++) begin
            fail_idx = vecs[i].fail; bresp_val = vecs[i].bresp;
            rresp_val = vecs[i].rresp; rdata_val = vecs[i].rdata;
            wr_start = wr_count; b0 = b_count; a0 = ar_count; av0 = ar_valid_cycles;
            issue_cmd(vecs[i].mode, vecs[i].obs);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_res(d, e, c, rr);
            finish_res();
            check($sformatf("v%0d_data", i), d, vecs[i].exp_data);
            check($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_code", i), 32'(c), 32'(vecs[i].exp_code));
            check($sformatf("v%0d_writes", i), 32'(wr_count - wr_start), 32'(vecs[i].exp_writes));
            check($sformatf("v%0d_bresps", i), 32'(b_count - b0), 32'(vecs[i].exp_writes));
            check($sformatf("v%0d_reads", i), 32'(ar_count - a0), 32'(vecs[i].exp_reads));
            if (vecs[i].exp_reads == 0)
                check($sformatf("v%0d_no_ar_valid", i), 32'(ar_valid_cycles - av0), 32'd0);
            for (int k = 0; k < vecs[i].exp_writes; k++) begin
                check($sformatf("v%0d_w%0d_addr", i, k), log_addr[8'(wr_start + k)], exp_addr(k));
                check($sformatf("v%0d_w%0d_data", i, k), log_data[8'(wr_start + k)],
                      exp_wdata(k, vecs[i].mode, vecs[i].obs));
            end
            check($sformatf("v%0d_idle_ready", i), 32'(cmd_ready), 32'd1);
        end
        fail_idx = -1; rresp_val = 2'b00;

        // Reset in the middle of a write phase
        aw_delay = 10; w_delay = 10;
        issue_cmd(1'b1, 36'h0);
        check("midwr_aw_valid", 32'(axi_bus.aw_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midwr_valids_dropped", {30'b0, axi_bus.aw_valid, axi_bus.w_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midwr_cmd_ready", 32'(cmd_ready), 32'd1);
        check("midwr_res_valid", 32'(res_valid), 32'd0);
        check("midwr_busy", 32'(busy), 32'd0);

        // Skewed write ready: AW accepted 3 cycles before W on every write
        aw_delay = 0; w_delay = 3;
        rdata_val = 32'h0BAD_F00D;
        wr_start = wr_count; b0 = b_count; s0 = skew_cycles; v0 = viol;
        issue_cmd(1'b1, {9'h1FF, 9'h0A5, 9'h012, 9'h003});
        wait_res(d, e, c, rr);
        finish_res();
        check("skew_data", d, 32'h0BAD_F00D);
        check("skew_code", 32'(c), 32'd0);
        check("skew_w_only_cycles", 32'(skew_cycles - s0), 32'd15);
        check("skew_one_b_per_write", 32'(b_count - b0), 32'(wr_count - wr_start));
        check("skew_writes", 32'(wr_count - wr_start), 32'd5);
        check("skew_protocol_viol", 32'(viol - v0), 32'd0);
        w_delay = 0;

        // Read data never arrives: abort TO cycles after RR entry
        r_never = 1'b1;
        issue_cmd(1'b0, 36'h123456789);
        wait_res(d, e, c, rr);
        check("rto_rr_cycles", 32'(rr), 32'(TO));
        check("rto_code", 32'(c), 32'd3);
        check("rto_err", 32'(e), 32'd1);
        check("rto_data", d, 32'd0);
        check("rto_r_ready_low", 32'(axi_bus.r_ready), 32'd0);
        finish_res();
        r_never = 1'b0;

        // Write address never accepted: abort in the write phase
        aw_delay = 40; w_delay = 40;
        wr_start = wr_count;
        issue_cmd(1'b1, 36'h0);
        wait_res(d, e, c, rr);
        check("wto_code", 32'(c), 32'd3);
        check("wto_valids_low", {30'b0, axi_bus.aw_valid, axi_bus.w_valid}, 32'd0);
        check("wto_writes", 32'(wr_count - wr_start), 32'd0);
        finish_res();
        aw_delay = 0; w_delay = 0;

        // Result backpressure
        res_ready = 1'b0;
        rdata_val = 32'h5A5A_C3C3;
        issue_cmd(1'b1, {9'h001, 9'h002, 9'h003, 9'h004});
        wait_res(d0, e, c, rr);
        check("bp_data", d0, 32'h5A5A_C3C3);
        cmd_mode = 1'b0; cmd_obs = {9'h1F0, 9'h00F, 9'h0F0, 9'h10F}; cmd_valid = 1'b1;
        bp_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== d0 || cmd_ready !== 1'b0 || busy !== 1'b1) bp_bad++;
        end
        check("bp_hold_stable", 32'(bp_bad), 32'd0);
        rdata_val = 32'h1357_9BDF;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {30'b0, cmd_ready, busy}, 32'h2);
        @(negedge clk);
        check("bp_next_accepted", {30'b0, cmd_ready, busy}, 32'h1);
        cmd_valid = 1'b0;
        wait_res(d, e, c, rr);
        finish_res();
        check("bp_next_data", d, 32'h1357_9BDF);
        check("bp_next_code", 32'(c), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
